gol_data_mem: RTL
=================

GOL_DATA_MEM -- requirements
Module: gol_data_mem

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning data RAM depth in 32-bit words.
REQ-002 SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles each framebuffer row is displayed.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_write  input  1  store strobe from the CPU, valid for one cycle per store.
REQ-006 SHALL have port alu_result  input  32  byte address from the CPU.
REQ-007 SHALL have port write_data  input  32  store data from the CPU.
REQ-008 SHALL have port read_data  output  32  load data to the CPU, combinational from alu_result.
REQ-009 SHALL have port row_sel  output  5  index of the framebuffer row being displayed.
REQ-010 SHALL have port row_data  output  32  front-buffer word for row_sel; bit n is column n.
REQ-011 SHALL have port row_en  output  1  high while the display row is lit.

Function
REQ-012 SHALL decode the address map as follows:
- 0x0000_0000..(4*RAM_WORDS-1): data RAM.
- 0x0000_1000..0x0000_107F: back framebuffer, 32 words.
- 0x0000_2000: CTRL; bit0 is swap_pending.
- 0x0000_2004: CYCLE, read-only.
- 0x0000_2008: FRAMES, read-only.
REQ-013 SHALL ignore alu_result[1:0]; all accesses are word accesses.
REQ-014 SHALL return 0 on read_data for unmapped addresses and SHALL drop writes to them, to CYCLE and to FRAMES.
REQ-015 SHALL provide reads with zero latency; a write with mem_write=1 SHALL be visible on read_data in the next cycle.
REQ-016 SHALL set swap_pending on a CTRL write with write_data[0]=1; a CTRL write with bit0=0 SHALL have no effect.
REQ-017 SHALL increment CYCLE by 1 every cycle, wrapping 0xFFFF_FFFF to 0.
REQ-018 SHALL implement two 32-word framebuffers; the fb_sel bit SHALL select which buffer is front (display) and which is back (CPU).
REQ-019 SHALL implement the scan FSM:
- BLANK: row_en=0 for exactly 1 cycle, then SHOW.
- SHOW: row_en=1 for SCAN_DIV cycles; then row_sel increments and the FSM returns to BLANK.
REQ-020 SHALL treat the SHOW-exit of row 31 as the frame boundary:
- row_sel wraps to 0.
- FRAMES increments by 1.
- If swap_pending was 1 before the edge, fb_sel toggles and swap_pending clears.
REQ-021 SHALL let a CTRL write in the same cycle as a frame boundary set swap_pending; the swap it requests SHALL happen at the following boundary.
REQ-022 SHALL direct a back-buffer write in the same cycle as a swap to the buffer that was back before that edge.
REQ-023 SHALL drive row_data from the front buffer registered at BLANK entry, so it is stable throughout SHOW.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, clear: CYCLE=0, FRAMES=0, swap_pending=0, fb_sel=0, FSM=BLANK, row_sel=0, row_data=0, row_en=0, divider=0.
REQ-025 SHALL NOT clear RAM or framebuffer contents on reset.
REQ-026 SHALL abandon a reset asserted mid-row or mid-frame immediately, with no swap and no FRAMES increment.
REQ-027 SHALL ignore writes presented during a reset cycle.

Structure
REQ-028 SHALL place address constants, CTRL bit index and the scan-state enum in package gol_mmio_pkg.
REQ-029 SHALL implement the scan FSM, divider and row_sel in one sub-module gol_fb_scan; frame_end SHALL be an output of gol_fb_scan.
REQ-030 SHALL keep storage and address decode in gol_data_mem.

Verification
REQ-031 SHALL check: write 0x1234_5678 to 0x10, then read 0x10 -> read_data=0x1234_5678; read 0x3000 -> 0.
REQ-032 SHALL check: SCAN_DIV=4, after reset -> row_en pattern 0,1,1,1,1,0,... and row_sel steps 0->1 after 5 cycles.
REQ-033 SHALL check: write 0xAAAA_AAAA to back row 0 (0x1000), then CTRL=1 -> at first frame boundary fb_sel=1 and swap_pending=0, and row 0 then shows row_data=0xAAAA_AAAA.
REQ-034 SHALL check: CTRL=1 written in the frame-boundary cycle -> no swap at that boundary, swap at the next; FRAMES increments at both.
REQ-035 SHALL check: assert reset mid-row 17 with swap_pending=1 -> all REQ-024 values, RAM content kept.
REQ-036 SHALL check: read CYCLE at two loads 10 cycles apart -> difference 10; a write to 0x2004 leaves CYCLE unchanged.

Source files
------------

// File: rtl/gol_mmio_pkg.sv
// Shared address map, CTRL bit layout and scan-state encoding for the Game-of-Life data memory.
// Latency: none (constants and types only).
// Backpressure: none.
package gol_mmio_pkg;

  // Framebuffer geometry: 32 rows of 32 columns, one word per row.
  localparam int FB_ROWS = 32;
  localparam int ROW_W   = 5;

  // Memory-mapped register and window addresses (word aligned).
  localparam logic [31:0] ADDR_FB_BASE = 32'h0000_1000;
  localparam logic [31:0] ADDR_FB_LAST = 32'h0000_107F;
  localparam logic [31:0] ADDR_CTRL    = 32'h0000_2000;
  localparam logic [31:0] ADDR_CYCLE   = 32'h0000_2004;
  localparam logic [31:0] ADDR_FRAMES  = 32'h0000_2008;

  // CTRL bit that requests a front/back swap at the next frame boundary.
  localparam int CTRL_SWAP_BIT = 0;

  // Display scan states: a one-cycle blank gap, then the lit row.
  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/gol_fb_scan.sv
// Row scanner: one BLANK cycle then SCAN_DIV lit cycles per row, 32 rows per frame.
// Latency: row_sel/row_en follow the registered state; load/frame_end are combinational strobes.
// Backpressure: none; free-running from reset.
module gol_fb_scan
  import gol_mmio_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ROW_W-1:0] row_sel_o,
  output logic             row_en_o,
  output logic             load_o,
  output logic             frame_end_o
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  scan_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Next-state and strobes: BLANK loads the row word, SHOW counts the divider.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    row_d       = row_q;
    row_en_o    = 1'b0;
    load_o      = 1'b0;
    frame_end_o = 1'b0;
    case (state_q)
      SCAN_BLANK: begin
        load_o  = 1'b1;
        div_d   = '0;
        state_d = SCAN_SHOW;
      end
      SCAN_SHOW: begin
        row_en_o = 1'b1;
        if (div_q == DIV_LAST) begin
          div_d       = '0;
          row_d       = row_q + 1'b1;
          state_d     = SCAN_BLANK;
          frame_end_o = (row_q == ROW_W'(FB_ROWS - 1));
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase
  end

  // State, divider and row registers; reset abandons any row in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN_BLANK;
      div_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      row_q   <= row_d;
    end
  end

  assign row_sel_o = row_q;

endmodule

// File: rtl/gol_data_mem.sv
// CPU data memory with double-buffered 32x32 framebuffer, CTRL/CYCLE/FRAMES registers and row scan.
// Latency: reads combinational from alu_result; writes visible the cycle after mem_write.
// Backpressure: none; every access completes in one cycle, unmapped writes are dropped.
module gol_data_mem
  import gol_mmio_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int SCAN_DIV  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_write,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  output logic [ROW_W-1:0] row_sel,
  output logic [31:0]      row_data,
  output logic             row_en
);

  localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] fb0_q [FB_ROWS];
  logic [31:0] fb1_q [FB_ROWS];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] frames_q, frames_d;
  logic [31:0] row_data_q, row_data_d;
  logic        swap_pending_q, swap_pending_d;
  logic        fb_sel_q, fb_sel_d;

  logic [31:0]       addr_w;
  logic [RAM_AW-1:0] ram_idx;
  logic [ROW_W-1:0]  fb_idx;
  logic              in_ram, in_fb, is_ctrl, is_cycle, is_frames;
  logic              wr_en, frame_end, load_row;
  logic [31:0]       back_rd, front_rd, ctrl_word;

  // Byte offset bits are masked off: every access is a whole word.
  assign addr_w    = alu_result & ~32'h3;
  assign ram_idx   = addr_w[RAM_AW+1:2];
  assign fb_idx    = addr_w[ROW_W+1:2];
  assign in_ram    = (addr_w < RAM_BYTES);
  assign in_fb     = (addr_w >= ADDR_FB_BASE) && (addr_w <= ADDR_FB_LAST);
  assign is_ctrl   = (addr_w == ADDR_CTRL);
  assign is_cycle  = (addr_w == ADDR_CYCLE);
  assign is_frames = (addr_w == ADDR_FRAMES);

  // Stores presented while reset is high are discarded.
  assign wr_en = mem_write & ~reset;

  // fb_sel=0: fb0 is front, fb1 is back; fb_sel=1 swaps the roles.
  assign back_rd  = fb_sel_q ? fb0_q[fb_idx]  : fb1_q[fb_idx];
  assign front_rd = fb_sel_q ? fb1_q[row_sel] : fb0_q[row_sel];

  gol_fb_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk         (clk),
    .reset       (reset),
    .row_sel_o   (row_sel),
    .row_en_o    (row_en),
    .load_o      (load_row),
    .frame_end_o (frame_end)
  );

  // Load mux; anything outside the map reads as zero.
  always_comb begin
    ctrl_word                = '0;
    ctrl_word[CTRL_SWAP_BIT] = swap_pending_q;
    read_data                = '0;
    if (in_ram)         read_data = ram_q[ram_idx];
    else if (in_fb)     read_data = back_rd;
    else if (is_ctrl)   read_data = ctrl_word;
    else if (is_cycle)  read_data = cycle_q;
    else if (is_frames) read_data = frames_q;
  end

  // Data RAM store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && in_ram) ram_q[ram_idx] <= write_data;
  end

  // Back-buffer store uses the pre-edge fb_sel, so a store racing a swap lands in the old back buffer.
  always_ff @(posedge clk) begin
    if (wr_en && in_fb) begin
      if (fb_sel_q) fb0_q[fb_idx] <= write_data;
      else          fb1_q[fb_idx] <= write_data;
    end
  end

  // Control next-state: the boundary consumes the pending swap, then a same-cycle CTRL write re-arms it.
  always_comb begin
    cycle_d        = cycle_q + 32'd1;
    frames_d       = frames_q;
    fb_sel_d       = fb_sel_q;
    swap_pending_d = swap_pending_q;
    row_data_d     = row_data_q;
    if (frame_end) begin
      frames_d = frames_q + 32'd1;
      if (swap_pending_q) begin
        fb_sel_d       = ~fb_sel_q;
        swap_pending_d = 1'b0;
      end
    end
    if (wr_en && is_ctrl && write_data[CTRL_SWAP_BIT]) swap_pending_d = 1'b1;
    // Latch the front word during BLANK so it is stable for the whole SHOW period.
    if (load_row) row_data_d = front_rd;
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q        <= '0;
      frames_q       <= '0;
      fb_sel_q       <= 1'b0;
      swap_pending_q <= 1'b0;
      row_data_q     <= '0;
    end else begin
      cycle_q        <= cycle_d;
      frames_q       <= frames_d;
      fb_sel_q       <= fb_sel_d;
      swap_pending_q <= swap_pending_d;
      row_data_q     <= row_data_d;
    end
  end

  assign row_data = row_data_q;

endmodule
